// File: rtl/cirno_pkg.sv
// Shared types and defaults for the cirno run-control slice.
package cirno_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} run_state_t;

  localparam int unsigned PROG_ID_W  = 2;
  localparam int unsigned START0_DEF = 0;
  localparam int unsigned START1_DEF = 128;
  localparam int unsigned START2_DEF = 256;

  function automatic logic [PROG_ID_W-1:0] next_prog_id(
    input logic [PROG_ID_W-1:0] id,
    input int unsigned          nprog
  );
    return (id == PROG_ID_W'(nprog - 1)) ? '0 : id + PROG_ID_W'(1);
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Bench/core handshake bundle for run_ctrl: req/ack plus core gating and status.
interface run_ctrl_if #(
  parameter int unsigned IW = 10,
  parameter int unsigned CW = 16
);
  logic                             init;
  logic                             halt;
  logic                             pc_load;
  logic [IW-1:0]                    pc_start;
  logic                             core_en;
  logic [cirno_pkg::PROG_ID_W-1:0]  prog_id;
  logic                             done;
  logic                             timeout;
  logic [CW-1:0]                    cycles;

  modport master (
    output init, halt,
    input  pc_load, pc_start, core_en, prog_id, done, timeout, cycles
  );

  modport slave (
    input  init, halt,
    output pc_load, pc_start, core_en, prog_id, done, timeout, cycles
  );
endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: starts programs in rotation, gates the core,
// and reports completion by halt or timeout with the run's cycle count.
module run_ctrl
  import cirno_pkg::*;
#(
  parameter int unsigned IW      = 10,
  parameter int unsigned NPROG   = 3,
  parameter int unsigned START0  = START0_DEF,
  parameter int unsigned START1  = START1_DEF,
  parameter int unsigned START2  = START2_DEF,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 60000
) (
  input  logic       clk,
  input  logic       reset,
  run_ctrl_if.slave  bus
);

  run_state_t           state_q, state_d;
  logic                 pc_load_d, core_en_d, done_d, timeout_d;
  logic [PROG_ID_W-1:0] prog_id_d;
  logic [IW-1:0]        pc_start_d, start_sel;
  logic                 cnt_clear, cnt_en;
  logic                 at_limit;

  always_comb begin
    case (bus.prog_id)
      PROG_ID_W'(1): start_sel = IW'(START1);
      PROG_ID_W'(2): start_sel = IW'(START2);
      default:       start_sel = IW'(START0);
    endcase
  end

  assign at_limit = (bus.cycles == CW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    pc_load_d  = 1'b0;
    core_en_d  = 1'b0;
    done_d     = bus.done;
    timeout_d  = bus.timeout;
    prog_id_d  = bus.prog_id;
    pc_start_d = bus.pc_start;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.init) begin
          state_d    = LOAD;
          pc_load_d  = 1'b1;
          pc_start_d = start_sel;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          cnt_clear  = 1'b1;
        end
      end
      LOAD: begin
        state_d   = RUN;
        core_en_d = 1'b1;
      end
      RUN: begin
        // Halt wins over the timeout limit and over a concurrent init.
        if (bus.halt) begin
          state_d   = DONE;
          done_d    = 1'b1;
          prog_id_d = next_prog_id(bus.prog_id, NPROG);
        end else if (at_limit) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          prog_id_d = next_prog_id(bus.prog_id, NPROG);
        end else begin
          core_en_d = 1'b1;
          cnt_en    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bus.pc_load  <= 1'b0;
      bus.core_en  <= 1'b0;
      bus.done     <= 1'b0;
      bus.timeout  <= 1'b0;
      bus.prog_id  <= '0;
      bus.pc_start <= IW'(START0);
    end else begin
      state_q      <= state_d;
      bus.pc_load  <= pc_load_d;
      bus.core_en  <= core_en_d;
      bus.done     <= done_d;
      bus.timeout  <= timeout_d;
      bus.prog_id  <= prog_id_d;
      bus.pc_start <= pc_start_d;
    end
  end

  sat_counter #(
    .W (CW)
  ) u_cycles (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .count (bus.cycles)
  );

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed scenarios plus random init/halt/reset traffic
// compared every cycle against a timeline model of each run.
module tb_run_ctrl;

  localparam int unsigned TO = 50;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_on = 0;

  run_ctrl_if #(.IW(10), .CW(16)) bus ();

  run_ctrl #(
    .IW      (10),
    .NPROG   (3),
    .CW      (16),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is a timeline counted from the accepted init edge.
  // t==0 is the load cycle, t>=1 are execution cycles until halt/limit.
  bit          running = 0;
  int unsigned t = 0;
  int unsigned m_cycles = 0;
  int unsigned m_pid = 0;
  int unsigned m_pcs = 0;
  bit          m_done = 0;
  bit          m_to = 0;

  function automatic int unsigned start_addr(input int unsigned id);
    int unsigned tbl [3] = '{0, 128, 256};
    return tbl[id];
  endfunction

  task automatic end_run(input bit by_limit);
    running = 0;
    m_done  = 1;
    m_to    = by_limit;
    m_pid   = (m_pid + 1) % 3;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      running = 0; t = 0; m_cycles = 0; m_pid = 0;
      m_pcs = 0; m_done = 0; m_to = 0;
    end else if (!running) begin
      if (bus.init) begin
        running = 1; t = 0; m_done = 0; m_to = 0; m_cycles = 0;
        m_pcs = start_addr(m_pid);
      end
    end else if (t == 0) begin
      t = 1;
    end else if (bus.halt) begin
      end_run(0);
    end else if (m_cycles == TO - 1) begin
      end_run(1);
    end else begin
      m_cycles++;
      t++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("pc_load",  32'(bus.pc_load),  32'(running && t == 0));
      chk("core_en",  32'(bus.core_en),  32'(running && t >= 1));
      chk("pc_start", 32'(bus.pc_start), m_pcs);
      chk("prog_id",  32'(bus.prog_id),  m_pid);
      chk("done",     32'(bus.done),     32'(m_done));
      chk("timeout",  32'(bus.timeout),  32'(m_to));
      chk("cycles",   32'(bus.cycles),   m_cycles);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_init();
    bus.init = 1'b1;
    tick(1);
    bus.init = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic do_run(input int k, input int pcs, input int pid_after);
    int en_cnt;
    pulse_init();
    chk("run_pc_load", 32'(bus.pc_load), 1);
    chk("run_pc_start", 32'(bus.pc_start), 32'(pcs));
    chk("run_done_low", 32'(bus.done), 0);
    tick(1);
    en_cnt = 0;
    for (int j = 0; j < k; j++) begin
      en_cnt += int'(bus.core_en);
      tick(1);
    end
    bus.halt = 1'b1;
    tick(1);
    bus.halt = 1'b0;
    chk("run_en_cycles", 32'(en_cnt), 32'(k));
    chk("run_done", 32'(bus.done), 1);
    chk("run_cycles", 32'(bus.cycles), 32'(k));
    chk("run_timeout", 32'(bus.timeout), 0);
    chk("run_core_en_off", 32'(bus.core_en), 0);
    chk("run_prog_id", 32'(bus.prog_id), 32'(pid_after));
  endtask

  initial begin
    bus.init = 1'b0;
    bus.halt = 1'b0;
    reset    = 1'b1;
    tick(2);
    cmp_on   = 1;
    reset    = 1'b0;
    tick(5);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_core_en", 32'(bus.core_en), 0);
    chk("rst_pc_load", 32'(bus.pc_load), 0);
    chk("rst_prog_id", 32'(bus.prog_id), 0);
    chk("rst_cycles", 32'(bus.cycles), 0);

    do_run(20, 0, 1);

    do_reset();
    do_run(5, 0, 1);
    do_run(7, 128, 2);
    do_run(9, 256, 0);

    pulse_init();
    begin
      int budget = 200;
      while (!bus.done && budget > 0) begin
        tick(1);
        budget--;
      end
      chk("to_reached", 32'(budget > 0), 1);
    end
    chk("to_done", 32'(bus.done), 1);
    chk("to_timeout", 32'(bus.timeout), 1);
    chk("to_cycles", 32'(bus.cycles), 49);
    chk("to_core_en", 32'(bus.core_en), 0);
    chk("to_prog_id", 32'(bus.prog_id), 1);
    pulse_init();
    chk("to_clear", 32'(bus.timeout), 0);
    chk("to_done_clear", 32'(bus.done), 0);
    chk("to_next_pc", 32'(bus.pc_start), 128);

    tick(3);
    pulse_init();
    chk("init_in_run_load", 32'(bus.pc_load), 0);
    chk("init_in_run_en", 32'(bus.core_en), 1);
    bus.halt = 1'b1;
    bus.init = 1'b1;
    tick(1);
    bus.halt = 1'b0;
    bus.init = 1'b0;
    chk("halt_init_done", 32'(bus.done), 1);
    chk("halt_init_pid", 32'(bus.prog_id), 2);
    tick(2);
    chk("halt_init_noload", 32'(bus.pc_load), 0);
    chk("halt_init_pid2", 32'(bus.prog_id), 2);

    do_reset();
    bus.halt = 1'b1;
    tick(3);
    bus.halt = 1'b0;
    chk("idle_halt_en", 32'(bus.core_en), 0);
    chk("idle_halt_done", 32'(bus.done), 0);
    chk("idle_halt_pid", 32'(bus.prog_id), 0);

    do_run(3, 0, 1);
    pulse_init();
    tick(4);
    do_reset();
    chk("midrst_en", 32'(bus.core_en), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_pid", 32'(bus.prog_id), 0);
    pulse_init();
    chk("midrst_load", 32'(bus.pc_load), 1);
    chk("midrst_pc", 32'(bus.pc_start), 0);
    tick(2);
    bus.halt = 1'b1;
    tick(1);
    bus.halt = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 299) == 0);
      bus.init = ($urandom_range(0, 9) == 0);
      bus.halt = ($urandom_range(0, 14) == 0);
      tick(1);
    end
    reset    = 1'b0;
    bus.init = 1'b0;
    bus.halt = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
